// File: rtl/tag_resolver_if.sv
// tag_resolver_if: controller <-> resolver bundle (scan control, match handshake, status).
interface tag_resolver_if #(
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
);
    logic                      start;
    logic [DATA_DEPTH-1:0]     tag_row;
    logic                      flush;
    logic                      match_ready;
    logic                      match_valid;
    logic [ADDR_WIDTH_CAM-1:0] match_addr;
    logic                      busy;
    logic                      done;
    logic                      any_match;
    logic [ADDR_WIDTH_CAM:0]   match_count;
    modport master (
        output start, tag_row, flush, match_ready,
        input  match_valid, match_addr, busy, done, any_match, match_count
    );
    modport slave (
        input  start, tag_row, flush, match_ready,
        output match_valid, match_addr, busy, done, any_match, match_count
    );
endinterface

// File: rtl/tag_resolver.sv
// tag_resolver: snapshots a CAM match vector and emits matching row addresses lowest-first.
// Optional macro TAG_RESOLVER_FIRST_ONLY_EN ends each scan after the first accepted match.
module tag_resolver #(
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
) (
    input logic           clk,
    input logic           rst_In,
    tag_resolver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t                    r_state, w_next;
    logic [DATA_DEPTH-1:0]     r_pending, w_rem;
    logic [ADDR_WIDTH_CAM-1:0] r_addr;
    logic [ADDR_WIDTH_CAM:0]   r_count;
    logic                      r_valid, r_any, w_hs, w_last, w_take;

    function automatic logic [ADDR_WIDTH_CAM-1:0] lowest(input logic [DATA_DEPTH-1:0] v);
        lowest = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--)
            if (v[i]) lowest = ADDR_WIDTH_CAM'(i);
    endfunction

    assign w_hs   = r_valid && bus.match_ready;
    assign w_take = r_state == IDLE && bus.start;
    // Next index comes from pending with the accepted bit already masked, keeping one match per cycle
    assign w_rem  = r_pending & ~(DATA_DEPTH'(1) << r_addr);
`ifdef TAG_RESOLVER_FIRST_ONLY_EN
    assign w_last = 1'b1;
`else
    assign w_last = w_rem == '0;
`endif

    always_ff @(posedge clk or negedge rst_In)
        if (!rst_In) r_state <= IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = bus.flush         ? IDLE :
                 r_state == IDLE   ? (bus.start ? (|bus.tag_row ? EMIT : DONE) : IDLE) :
                 r_state == EMIT   ? (w_hs && w_last ? DONE : EMIT) :
                                     IDLE;
    end

    always_comb begin
        bus.busy        = r_state != IDLE;
        bus.done        = r_state == DONE;
        bus.match_valid = r_valid;
        bus.match_addr  = r_addr;
        bus.any_match   = r_any;
        bus.match_count = r_count;
    end

    always_ff @(posedge clk or negedge rst_In)
        if (!rst_In) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_any     <= 1'b0;
            r_count   <= '0;
        end else if (bus.flush) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
        end else if (w_take) begin
            r_pending <= bus.tag_row;
            r_any     <= |bus.tag_row;
            r_count   <= '0;
            r_valid   <= |bus.tag_row;
            r_addr    <= lowest(bus.tag_row);
        end else if (w_hs) begin
            r_pending <= w_rem;
            r_count   <= r_count + (ADDR_WIDTH_CAM + 1)'(1);
            r_valid   <= !w_last;
            if (!w_last) r_addr <= lowest(w_rem);
        end
endmodule
